// File: rtl/aes_cbc_dec_ctrl_pkg.sv
// Shared definitions for the CBC inverse-cipher stream controller.
//   AES_BLK_W : width of one AES block
//   CNT_W     : key-expansion wait counter width
//   TCNT_W    : done-timeout counter width
//   state_e   : controller FSM encoding
//   blk_t     : one 128-bit block
package aes_cbc_dec_ctrl_pkg;

   localparam int unsigned AES_BLK_W = 128;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned TCNT_W    = 6;

   typedef logic [AES_BLK_W-1:0] blk_t;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StKeyExp = 3'd1,
      StReady  = 3'd2,
      StLoad   = 3'd3,
      StRun    = 3'd4,
      StOut    = 3'd5
   } state_e;

endpackage

// File: rtl/aes_cbc_dec_ctrl_if.sv
// Stream bundle between a key/ciphertext source, the controller and a plaintext sink.
//   key_vld/key_rdy/key_in/iv_in : key + IV load handshake
//   ct_vld/ct_rdy/ct_data        : ciphertext block stream into the controller
//   pt_vld/pt_rdy/pt_data        : plaintext block stream out of the controller
// master = traffic side (bench / parent), slave = controller.
interface aes_cbc_dec_ctrl_if;
   import aes_cbc_dec_ctrl_pkg::*;

   logic key_vld;
   logic key_rdy;
   blk_t key_in;
   blk_t iv_in;
   logic ct_vld;
   logic ct_rdy;
   blk_t ct_data;
   logic pt_vld;
   logic pt_rdy;
   blk_t pt_data;

   modport master (
      output key_vld, key_in, iv_in, ct_vld, ct_data, pt_rdy,
      input  key_rdy, ct_rdy, pt_vld, pt_data
   );

   modport slave (
      input  key_vld, key_in, iv_in, ct_vld, ct_data, pt_rdy,
      output key_rdy, ct_rdy, pt_vld, pt_data
   );

endinterface

// File: rtl/aes_cbc_dec_ctrl.sv
// Front/back end for a non-pipelined 128-bit inverse-cipher core (kld/ld/done interface).
// Loads key and IV, feeds one ciphertext block at a time, captures the core result on
// done and applies CBC unchaining before presenting plaintext downstream.
//   clk, rst        : clock, synchronous active-high reset (shared with the core)
//   bus             : key / ciphertext / plaintext streams (slave side)
//   core_kld        : one-cycle key-load pulse, core_key already holds the new key
//   core_key        : key register to core
//   core_ld         : one-cycle block-load pulse
//   core_text_in    : ciphertext register, stable from core_ld until done
//   core_done       : core completion pulse, core_text_out valid in the same cycle
//   core_text_out   : core result
//   busy            : block in flight (load / run / output)
//   err_timeout     : sticky, core failed to answer within DONE_TIMEOUT cycles
module aes_cbc_dec_ctrl
   import aes_cbc_dec_ctrl_pkg::*;
#(
   parameter bit          CBC_EN       = 1'b1,
   parameter int unsigned KEY_WAIT     = 14,
   parameter int unsigned DONE_TIMEOUT = 32
) (
   input  logic                clk,
   input  logic                rst,
   aes_cbc_dec_ctrl_if.slave   bus,
   output logic                core_kld,
   output blk_t                core_key,
   output logic                core_ld,
   output blk_t                core_text_in,
   input  logic                core_done,
   input  blk_t                core_text_out,
   output logic                busy,
   output logic                err_timeout
);

   localparam logic [CNT_W-1:0]  KeyLast  = CNT_W'(KEY_WAIT - 1);
   localparam logic [TCNT_W-1:0] TcntLast = TCNT_W'(DONE_TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   blk_t                key_q, key_d;
   blk_t                chain_q, chain_d;
   blk_t                text_q, text_d;
   blk_t                pt_q, pt_d;
   logic                kld_q, kld_d;
   logic                err_q, err_d;
   logic                key_rdy;
   logic                key_acc;

   assign key_rdy = (state_q == StIdle) || (state_q == StReady);
   assign key_acc = bus.key_vld && key_rdy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      key_d   = key_q;
      chain_d = chain_q;
      text_d  = text_q;
      pt_d    = pt_q;
      kld_d   = 1'b0;
      err_d   = err_q;

      // A new key always wins over a pending ciphertext and restarts the chain.
      if (key_acc) begin
         key_d   = bus.key_in;
         chain_d = bus.iv_in;
         kld_d   = 1'b1;
         cnt_d   = '0;
         err_d   = 1'b0;
         state_d = StKeyExp;
      end else begin
         case (state_q)
            StIdle: ;
            StKeyExp: begin
               if (cnt_q == KeyLast) begin
                  state_d = StReady;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StReady: begin
               if (bus.ct_vld) begin
                  text_d  = bus.ct_data;
                  state_d = StLoad;
               end
            end
            StLoad: begin
               tcnt_d  = '0;
               state_d = StRun;
            end
            StRun: begin
               if (core_done) begin
                  pt_d    = core_text_out ^ (CBC_EN ? chain_q : '0);
                  chain_d = text_q;
                  state_d = StOut;
               end else if (tcnt_q == TcntLast) begin
                  // Block is dropped; chain keeps the last good ciphertext.
                  err_d   = 1'b1;
                  state_d = StReady;
               end else begin
                  tcnt_d = tcnt_q + TCNT_W'(1);
               end
            end
            StOut: begin
               if (bus.pt_rdy) begin
                  state_d = StReady;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         key_q   <= '0;
         chain_q <= '0;
         text_q  <= '0;
         pt_q    <= '0;
         kld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         key_q   <= key_d;
         chain_q <= chain_d;
         text_q  <= text_d;
         pt_q    <= pt_d;
         kld_q   <= kld_d;
         err_q   <= err_d;
      end
   end

   assign bus.key_rdy  = key_rdy;
   assign bus.ct_rdy   = (state_q == StReady) && !bus.key_vld;
   assign bus.pt_vld   = (state_q == StOut);
   assign bus.pt_data  = pt_q;
   assign core_kld     = kld_q;
   assign core_key     = key_q;
   assign core_ld      = (state_q == StLoad);
   assign core_text_in = text_q;
   assign busy         = (state_q == StLoad) || (state_q == StRun) || (state_q == StOut);
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
module tb_aes_cbc_dec_ctrl;
   import aes_cbc_dec_ctrl_pkg::*;

   localparam int unsigned KW = 14;
   localparam int unsigned DT = 32;

   // FIPS-197 C.1 and SP800-38A F.2.2 vectors
   localparam blk_t K_E  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam blk_t CT_E = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam blk_t PT_E = 128'h00112233445566778899aabbccddeeff;
   localparam blk_t K_C  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam blk_t IV_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam blk_t CT1  = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam blk_t PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam blk_t CT2  = 128'h5086cb9b507219ee95db113a917678b2;
   localparam blk_t PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

   // Raw inverse-cipher result: CBC plaintext with its chaining value removed.
   function automatic blk_t core_model(input blk_t key, input blk_t ct);
      if (key == K_E && ct == CT_E) return PT_E;
      if (key == K_C && ct == CT1) return PT1 ^ IV_C;
      if (key == K_C && ct == CT2) return PT2 ^ CT1;
      return ~ct;
   endfunction

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total;
   int bad;

   aes_cbc_dec_ctrl_if cif ();
   aes_cbc_dec_ctrl_if eif ();

   logic c_kld, c_ld, c_done, c_done_m, c_busy, c_err, kill, stray;
   blk_t c_key, c_text, c_out;
   logic [3:0] c_cnt;
   logic e_kld, e_ld, e_done, e_busy, e_err;
   blk_t e_key, e_text, e_out;
   logic [3:0] e_cnt;

   assign c_done = c_done_m | stray;

   aes_cbc_dec_ctrl #(.CBC_EN(1'b1), .KEY_WAIT(KW), .DONE_TIMEOUT(DT)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (cif),
      .core_kld      (c_kld),
      .core_key      (c_key),
      .core_ld       (c_ld),
      .core_text_in  (c_text),
      .core_done     (c_done),
      .core_text_out (c_out),
      .busy          (c_busy),
      .err_timeout   (c_err)
   );

   aes_cbc_dec_ctrl #(.CBC_EN(1'b0), .KEY_WAIT(KW), .DONE_TIMEOUT(DT)) u_dut_ecb (
      .clk           (clk),
      .rst           (rst),
      .bus           (eif),
      .core_kld      (e_kld),
      .core_key      (e_key),
      .core_ld       (e_ld),
      .core_text_in  (e_text),
      .core_done     (e_done),
      .core_text_out (e_out),
      .busy          (e_busy),
      .err_timeout   (e_err)
   );

   // Core models: fixed 10-cycle latency after core_ld.
   always @(posedge clk) begin
      if (rst) begin
         c_cnt <= '0; c_done_m <= 1'b0; c_out <= '0;
      end else begin
         c_done_m <= 1'b0;
         if (c_ld) c_cnt <= 4'd10;
         else if (c_cnt != 4'd0) begin
            c_cnt <= c_cnt - 4'd1;
            if (c_cnt == 4'd1 && !kill) begin
               c_done_m <= 1'b1;
               c_out    <= core_model(c_key, c_text);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         e_cnt <= '0; e_done <= 1'b0; e_out <= '0;
      end else begin
         e_done <= 1'b0;
         if (e_ld) e_cnt <= 4'd10;
         else if (e_cnt != 4'd0) begin
            e_cnt <= e_cnt - 4'd1;
            if (e_cnt == 4'd1) begin
               e_done <= 1'b1;
               e_out  <= core_model(e_key, e_text);
            end
         end
      end
   end

   task automatic load_key(input blk_t k, input blk_t iv);
      int n = 0;
      while (!cif.key_rdy && n < 100) begin @(negedge clk); n++; end
      cif.key_in = k; cif.iv_in = iv; cif.key_vld = 1'b1;
      @(negedge clk);
      cif.key_vld = 1'b0;
      total++;
      if (c_kld !== 1'b1 || c_key !== k || n >= 100) begin
         bad++;
         $display("FAIL key_load: kld=%b key=%h, expected kld=1 key=%h", c_kld, c_key, k);
      end
      n = 0;
      while (!cif.ct_rdy && n < 40) begin @(negedge clk); n++; end
      total++;
      if (n != KW) begin
         bad++;
         $display("FAIL key_wait: ct_rdy after %0d cycles, expected %0d", n, KW);
      end
   endtask

   task automatic send_ct(input blk_t ct);
      int n = 0;
      while (!cif.ct_rdy && n < 100) begin @(negedge clk); n++; end
      cif.ct_data = ct; cif.ct_vld = 1'b1;
      @(negedge clk);
      cif.ct_vld = 1'b0;
      total++;
      if (c_ld !== 1'b1 || c_text !== ct || n >= 100) begin
         bad++;
         $display("FAIL ct_load: ld=%b text=%h, expected ld=1 text=%h", c_ld, c_text, ct);
      end
   endtask

   task automatic recv_pt(input blk_t exp, input string name, output int lat);
      int n = 0;
      while (!cif.pt_vld && n < 100) begin @(negedge clk); n++; end
      lat = n;
      total++;
      if (cif.pt_vld !== 1'b1 || cif.pt_data !== exp || cif.ct_rdy !== 1'b0) begin
         bad++;
         $display("FAIL %s: vld=%b ct_rdy=%b data=%h, expected vld=1 ct_rdy=0 data=%h",
                  name, cif.pt_vld, cif.ct_rdy, cif.pt_data, exp);
      end
      cif.pt_rdy = 1'b1;
      @(negedge clk);
      cif.pt_rdy = 1'b0;
      total++;
      if (cif.pt_vld !== 1'b0 || cif.key_rdy !== 1'b1) begin
         bad++;
         $display("FAIL %s_release: pt_vld=%b key_rdy=%b, expected 0 1", name, cif.pt_vld,
                  cif.key_rdy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (cif.key_rdy !== 1'b1 || cif.ct_rdy !== 1'b0 || cif.pt_vld !== 1'b0 ||
          cif.pt_data !== '0 || c_busy !== 1'b0 || c_err !== 1'b0 || c_kld !== 1'b0 ||
          c_ld !== 1'b0 || c_key !== '0 || c_text !== '0) begin
         bad++;
         $display("FAIL reset_cbc: key_rdy=%b ct_rdy=%b pt_vld=%b busy=%b err=%b kld=%b ld=%b, expected 1 0 0 0 0 0 0",
                  cif.key_rdy, cif.ct_rdy, cif.pt_vld, c_busy, c_err, c_kld, c_ld);
      end
      total++;
      if (eif.key_rdy !== 1'b1 || eif.ct_rdy !== 1'b0 || eif.pt_vld !== 1'b0 ||
          e_busy !== 1'b0 || e_ld !== 1'b0) begin
         bad++;
         $display("FAIL reset_ecb: key_rdy=%b ct_rdy=%b pt_vld=%b busy=%b ld=%b, expected 1 0 0 0 0",
                  eif.key_rdy, eif.ct_rdy, eif.pt_vld, e_busy, e_ld);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ecb();
      int n = 0;
      eif.key_in = K_E; eif.iv_in = IV_C; eif.key_vld = 1'b1;
      @(negedge clk);
      eif.key_vld = 1'b0;
      while (!eif.ct_rdy && n < 40) begin @(negedge clk); n++; end
      eif.ct_data = CT_E; eif.ct_vld = 1'b1;
      @(negedge clk);
      eif.ct_vld = 1'b0;
      n = 0;
      while (!eif.pt_vld && n < 100) begin @(negedge clk); n++; end
      total++;
      if (eif.pt_vld !== 1'b1 || eif.pt_data !== PT_E) begin
         bad++;
         $display("FAIL ecb_pt: vld=%b data=%h, expected vld=1 data=%h", eif.pt_vld,
                  eif.pt_data, PT_E);
      end
      eif.pt_rdy = 1'b1;
      @(negedge clk);
      eif.pt_rdy = 1'b0;
      total++;
      if (eif.pt_vld !== 1'b0 || eif.ct_rdy !== 1'b1) begin
         bad++;
         $display("FAIL ecb_release: pt_vld=%b ct_rdy=%b, expected 0 1", eif.pt_vld, eif.ct_rdy);
      end
   endtask

   task automatic test_cbc();
      int lat;
      load_key(K_C, IV_C);
      send_ct(CT1);
      recv_pt(PT1, "cbc_pt1", lat);
      total++;
      if (lat != 12) begin
         bad++;
         $display("FAIL cbc_latency: %0d cycles from core_ld to pt_vld, expected 12", lat);
      end
      send_ct(CT2);
      recv_pt(PT2, "cbc_pt2", lat);
   endtask

   task automatic test_backpressure();
      int n = 0;
      int lat;
      load_key(K_C, IV_C);
      send_ct(CT1);
      while (!cif.pt_vld && n < 100) begin @(negedge clk); n++; end
      cif.ct_data = CT2; cif.ct_vld = 1'b1;
      for (int i = 0; i < 20; i++) begin
         total++;
         if (cif.pt_vld !== 1'b1 || cif.pt_data !== PT1 || cif.ct_rdy !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d: vld=%b ct_rdy=%b data=%h, expected vld=1 ct_rdy=0 data=%h",
                     i, cif.pt_vld, cif.ct_rdy, cif.pt_data, PT1);
         end
         @(negedge clk);
      end
      cif.pt_rdy = 1'b1;
      @(negedge clk);
      cif.pt_rdy = 1'b0;
      @(negedge clk);
      cif.ct_vld = 1'b0;
      total++;
      if (c_ld !== 1'b1 || c_text !== CT2) begin
         bad++;
         $display("FAIL hold_next_ct: ld=%b text=%h, expected ld=1 text=%h", c_ld, c_text, CT2);
      end
      recv_pt(PT2, "hold_pt2", lat);
   endtask

   task automatic test_collision();
      int n = 0;
      int lat;
      cif.key_in = K_C; cif.iv_in = IV_C; cif.key_vld = 1'b1;
      cif.ct_data = CT1; cif.ct_vld = 1'b1;
      #1;
      total++;
      if (cif.ct_rdy !== 1'b0 || cif.key_rdy !== 1'b1) begin
         bad++;
         $display("FAIL collide_rdy: ct_rdy=%b key_rdy=%b, expected 0 1", cif.ct_rdy, cif.key_rdy);
      end
      @(negedge clk);
      cif.key_vld = 1'b0;
      total++;
      if (c_kld !== 1'b1 || c_ld !== 1'b0 || c_busy !== 1'b0) begin
         bad++;
         $display("FAIL collide_key: kld=%b ld=%b busy=%b, expected 1 0 0", c_kld, c_ld, c_busy);
      end
      while (!c_ld && n < 40) begin @(negedge clk); n++; end
      cif.ct_vld = 1'b0;
      total++;
      if (n != KW + 1 || c_text !== CT1) begin
         bad++;
         $display("FAIL collide_ct: core_ld after %0d cycles text=%h, expected %0d text=%h",
                  n, c_text, KW + 1, CT1);
      end
      recv_pt(PT1, "collide_pt", lat);
   endtask

   task automatic test_timeout();
      int lat;
      kill = 1'b1;
      send_ct(CT2);
      repeat (32) @(negedge clk);
      total++;
      if (c_busy !== 1'b1 || c_err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_early: busy=%b err=%b, expected 1 0", c_busy, c_err);
      end
      @(negedge clk);
      total++;
      if (c_err !== 1'b1 || c_busy !== 1'b0 || cif.ct_rdy !== 1'b1 || cif.pt_vld !== 1'b0) begin
         bad++;
         $display("FAIL timeout_err: err=%b busy=%b ct_rdy=%b pt_vld=%b, expected 1 0 1 0",
                  c_err, c_busy, cif.ct_rdy, cif.pt_vld);
      end
      kill = 1'b0;
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      total++;
      if (cif.pt_vld !== 1'b0 || c_busy !== 1'b0) begin
         bad++;
         $display("FAIL stray_done: pt_vld=%b busy=%b, expected 0 0", cif.pt_vld, c_busy);
      end
      send_ct(CT2);
      recv_pt(PT2, "timeout_retry", lat);
      total++;
      if (c_err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: err=%b, expected 1", c_err);
      end
      load_key(K_C, IV_C);
      total++;
      if (c_err !== 1'b0) begin
         bad++;
         $display("FAIL err_clear: err=%b, expected 0", c_err);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      send_ct(CT1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (cif.key_rdy !== 1'b1 || cif.ct_rdy !== 1'b0 || cif.pt_vld !== 1'b0 ||
          cif.pt_data !== '0 || c_busy !== 1'b0 || c_err !== 1'b0 || c_kld !== 1'b0 ||
          c_ld !== 1'b0 || c_key !== '0 || c_text !== '0) begin
         bad++;
         $display("FAIL midrun_rst: key_rdy=%b busy=%b pt_data=%h key=%h text=%h, expected 1 0 and zeros",
                  cif.key_rdy, c_busy, cif.pt_data, c_key, c_text);
      end
      rst = 1'b0;
      cif.ct_data = CT2; cif.ct_vld = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (cif.ct_rdy !== 1'b0 || c_ld !== 1'b0 || c_busy !== 1'b0 || cif.pt_vld !== 1'b0) begin
            bad++;
            $display("FAIL no_key_%0d: ct_rdy=%b ld=%b busy=%b pt_vld=%b, expected all 0",
                     i, cif.ct_rdy, c_ld, c_busy, cif.pt_vld);
         end
      end
      cif.ct_vld = 1'b0;
      load_key(K_C, IV_C);
      send_ct(CT1);
      recv_pt(PT1, "reload_pt", lat);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; kill = 1'b0; stray = 1'b0;
      cif.key_vld = 1'b0; cif.key_in = '0; cif.iv_in = '0;
      cif.ct_vld = 1'b0; cif.ct_data = '0; cif.pt_rdy = 1'b0;
      eif.key_vld = 1'b0; eif.key_in = '0; eif.iv_in = '0;
      eif.ct_vld = 1'b0; eif.ct_data = '0; eif.pt_rdy = 1'b0;
      test_reset();
      test_ecb();
      test_cbc();
      test_backpressure();
      test_collision();
      test_timeout();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
